// File: rtl/fpu_seq.sv
// fpu_seq: runs one decoded FP operation at a time through the FPU datapath.
// An op is accepted from decode, classified by latency, started with a one-cycle
// pulse, waited on (fixed latency or unit_done), and its result is held for writeback.
module fpu_seq #(
  parameter int BUS_WIDTH  = 64,
  parameter int FPU_OP_LEN = 6,
  parameter int ADD_LAT    = 3,
  parameter int MUL_LAT    = 4,
  parameter int MAX_WAIT   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FPU_OP_LEN-1:0] in_op,
  input  logic [4:0]            in_rd,
  input  logic                  in_fpu_rd,
  output logic                  issue_start,
  output logic [FPU_OP_LEN-1:0] issue_op,
  output logic                  unit_abort,
  input  logic                  unit_done,
  input  logic [BUS_WIDTH-1:0]  unit_result,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [BUS_WIDTH-1:0]  wb_data,
  output logic [4:0]            wb_rd,
  output logic                  wb_fp,
  output logic                  illegal,
  output logic                  timeout
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;
  typedef enum logic [2:0] {
    CLS_ADD = 3'd0, CLS_MUL = 3'd1, CLS_LONG = 3'd2, CLS_SHORT = 3'd3, CLS_ILL = 3'd4
  } cls_t;

  // Wait counter is one bit wider than needed to hold MAX_WAIT-1.
  localparam int CNT_W = $clog2(MAX_WAIT) + 1;
  localparam logic [CNT_W-1:0] ADD_END  = CNT_W'(ADD_LAT - 1);
  localparam logic [CNT_W-1:0] MUL_END  = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] WAIT_END = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Map an fpu_op code onto its latency class.
  function automatic cls_t classify(input logic [FPU_OP_LEN-1:0] op);
    cls_t c;
    if (op <= FPU_OP_LEN'(3)) begin
      c = CLS_ADD;
    end else if (op <= FPU_OP_LEN'(5)) begin
      c = CLS_MUL;
    end else if (op <= FPU_OP_LEN'(9)) begin
      c = CLS_LONG;
    end else if ((op >= FPU_OP_LEN'(16)) && (op <= FPU_OP_LEN'(39))) begin
      c = CLS_SHORT;
    end else begin
      c = CLS_ILL;
    end
    return c;
  endfunction

  state_t           state_r, state_nxt_s;
  cls_t             in_cls_s, cur_cls_r;
  logic [CNT_W-1:0] cnt_r;
  logic [4:0]       cur_rd_r;
  logic             cur_fp_r;
  logic             accept_s, accept_legal_s, capture_s, expire_s;

  assign in_cls_s       = classify(in_op);
  assign in_ready       = ~flush & ((state_r == IDLE) | ((state_r == WB) & wb_ready));
  assign accept_s       = in_valid & in_ready;
  assign accept_legal_s = accept_s & (in_cls_s != CLS_ILL);

  // Decide whether the in-flight op finishes (capture) or gives up (expire) this cycle.
  always_comb begin
    capture_s = 1'b0;
    expire_s  = 1'b0;
    if ((state_r == EXEC) && !flush) begin
      case (cur_cls_r)
        CLS_ADD:   capture_s = (cnt_r == ADD_END);
        CLS_MUL:   capture_s = (cnt_r == MUL_END);
        CLS_SHORT: capture_s = (cnt_r == CNT_ZERO);
        CLS_LONG: begin
          // unit_done in the start cycle belongs to no op of ours, so ignore it.
          capture_s = unit_done & (cnt_r != CNT_ZERO);
          expire_s  = ~unit_done & (cnt_r == WAIT_END);
        end
        default: begin
          capture_s = 1'b0;
          expire_s  = 1'b0;
        end
      endcase
    end else begin
      capture_s = 1'b0;
      expire_s  = 1'b0;
    end
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: state_nxt_s = accept_legal_s ? EXEC : IDLE;
        EXEC: begin
          if (capture_s) begin
            state_nxt_s = WB;
          end else if (expire_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = EXEC;
          end
        end
        WB: begin
          if (wb_ready) begin
            state_nxt_s = accept_legal_s ? EXEC : IDLE;
          end else begin
            state_nxt_s = WB;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Op latch, wait counter, pulses and writeback holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_start <= 1'b0;
      issue_op    <= {FPU_OP_LEN{1'b1}};
      unit_abort  <= 1'b0;
      illegal     <= 1'b0;
      timeout     <= 1'b0;
      cur_cls_r   <= CLS_ILL;
      cur_rd_r    <= 5'd0;
      cur_fp_r    <= 1'b0;
      cnt_r       <= CNT_ZERO;
      wb_valid    <= 1'b0;
      wb_data     <= {BUS_WIDTH{1'b0}};
      wb_rd       <= 5'd0;
      wb_fp       <= 1'b0;
    end else begin
      issue_start <= accept_legal_s;
      illegal     <= accept_s & (in_cls_s == CLS_ILL);
      timeout     <= expire_s;
      unit_abort  <= expire_s | (flush & (state_r == EXEC) & (cur_cls_r == CLS_LONG));
      if (accept_legal_s) begin
        issue_op  <= in_op;
        cur_cls_r <= in_cls_s;
        cur_rd_r  <= in_rd;
        cur_fp_r  <= in_fpu_rd;
        cnt_r     <= CNT_ZERO;
      end else if ((state_r == EXEC) && (cnt_r != WAIT_END)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
      if (flush) begin
        wb_valid <= 1'b0;
      end else if (capture_s) begin
        wb_valid <= 1'b1;
        wb_data  <= unit_result;
        wb_rd    <= cur_rd_r;
        wb_fp    <= cur_fp_r;
      end else if ((state_r == WB) && wb_ready) begin
        wb_valid <= 1'b0;
      end else begin
        wb_valid <= wb_valid;
      end
    end
  end

endmodule
